// File: rtl/ps2_pkg.sv
// Shared constants, byte-0 field map and frame FSM encoding for the PS/2 mouse receiver.
// frame_ok() is the odd-parity plus stop-bit acceptance rule for a received frame.
package ps2_pkg;

    localparam int unsigned FRAME_BITS = 11;

    localparam int unsigned BTN_L = 0;
    localparam int unsigned BTN_R = 1;
    localparam int unsigned BTN_M = 2;
    localparam int unsigned SYNC  = 3;
    localparam int unsigned XS    = 4;
    localparam int unsigned YS    = 5;
    localparam int unsigned XO    = 6;
    localparam int unsigned YO    = 7;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RECV  = 2'd1,
        CHECK = 2'd2
    } frame_state_e;

    function automatic logic frame_ok(input logic [8:0] data_par, input logic stop_bit);
        return (^data_par) & stop_bit;
    endfunction

endpackage

// File: rtl/ps2_frame_rx.sv
// PS/2 device-to-host frame receiver: clock falling-edge detect, 11-bit frame FSM,
// start/parity/stop check and inter-edge timeout. All outputs are registered.
module ps2_frame_rx
    import ps2_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 100000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] byte_data,
    output logic       byte_valid,
    output logic       frame_err
);

    localparam int unsigned TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

    frame_state_e  state_q, state_d;
    logic [3:0]    bit_cnt_q, bit_cnt_d;
    logic [8:0]    shift_q, shift_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic [7:0]    byte_q, byte_d;
    logic          bv_q, bv_d;
    logic          fe_q, fe_d;
    logic          ps2_clk_q;
    logic          sample_edge_s;

    assign sample_edge_s = ps2_clk_q & ~ps2_clk;

    // State register: everything clears on the synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= IDLE;
            bit_cnt_q <= 4'd0;
            shift_q   <= 9'd0;
            tmo_q     <= '0;
            byte_q    <= 8'd0;
            bv_q      <= 1'b0;
            fe_q      <= 1'b0;
            ps2_clk_q <= 1'b1;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            tmo_q     <= tmo_d;
            byte_q    <= byte_d;
            bv_q      <= bv_d;
            fe_q      <= fe_d;
            ps2_clk_q <= ps2_clk;
        end
    end

    // Next-state logic; the verdict is computed on the stop-bit edge so the pulse lands in CHECK.
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        tmo_d     = tmo_q;
        byte_d    = byte_q;
        bv_d      = 1'b0;
        fe_d      = 1'b0;
        case (state_q)
            IDLE: begin
                tmo_d = '0;
                if (sample_edge_s && !ps2_data) begin
                    state_d   = RECV;
                    bit_cnt_d = 4'd1;
                    shift_d   = 9'd0;
                end else begin
                    state_d = IDLE;
                end
            end
            RECV: begin
                if (sample_edge_s) begin
                    tmo_d = '0;
                    if (bit_cnt_q == 4'(FRAME_BITS - 1)) begin
                        state_d   = CHECK;
                        bit_cnt_d = 4'd0;
                        if (frame_ok(shift_q, ps2_data)) begin
                            byte_d = shift_q[7:0];
                            bv_d   = 1'b1;
                        end else begin
                            fe_d = 1'b1;
                        end
                    end else begin
                        shift_d   = {ps2_data, shift_q[8:1]};
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end
                end else if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
                    fe_d      = 1'b1;
                    state_d   = IDLE;
                    tmo_d     = '0;
                    bit_cnt_d = 4'd0;
                    shift_d   = 9'd0;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            CHECK: begin
                state_d = IDLE;
            end
            default: begin
                state_d   = IDLE;
                bit_cnt_d = 4'd0;
                tmo_d     = '0;
            end
        endcase
    end

    assign byte_data  = byte_q;
    assign byte_valid = bv_q;
    assign frame_err  = fe_q;

endmodule

// File: rtl/ps2_mouse_rx.sv
// PS/2 mouse receiver top: frame receiver plus a 3-byte movement packet assembler.
// Byte 0 must carry the sync bit; any frame error restarts packet alignment.
module ps2_mouse_rx
    import ps2_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 100000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] byte_data,
    output logic       byte_valid,
    output logic       frame_err,
    output logic       pkt_valid,
    output logic [2:0] buttons,
    output logic [8:0] dx,
    output logic [8:0] dy,
    output logic       x_ovf,
    output logic       y_ovf
);

    logic [7:0] byte_s;
    logic       byte_valid_s;
    logic       frame_err_s;

    logic [1:0] idx_q, idx_d;
    logic [7:0] b0_q, b0_d;
    logic [7:0] b1_q, b1_d;
    logic       pv_q, pv_d;
    logic [2:0] btn_q, btn_d;
    logic [8:0] dx_q, dx_d;
    logic [8:0] dy_q, dy_d;
    logic       xo_q, xo_d;
    logic       yo_q, yo_d;

    ps2_frame_rx #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_frame (
        .clk       (clk),
        .reset     (reset),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .byte_data (byte_s),
        .byte_valid(byte_valid_s),
        .frame_err (frame_err_s)
    );

    // Packet assembler and packet output registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            idx_q <= 2'd0;
            b0_q  <= 8'd0;
            b1_q  <= 8'd0;
            pv_q  <= 1'b0;
            btn_q <= 3'd0;
            dx_q  <= 9'd0;
            dy_q  <= 9'd0;
            xo_q  <= 1'b0;
            yo_q  <= 1'b0;
        end else begin
            idx_q <= idx_d;
            b0_q  <= b0_d;
            b1_q  <= b1_d;
            pv_q  <= pv_d;
            btn_q <= btn_d;
            dx_q  <= dx_d;
            dy_q  <= dy_d;
            xo_q  <= xo_d;
            yo_q  <= yo_d;
        end
    end

    // Advance on accepted bytes; the third byte is taken straight from the frame receiver.
    always_comb begin
        idx_d = idx_q;
        b0_d  = b0_q;
        b1_d  = b1_q;
        pv_d  = 1'b0;
        btn_d = btn_q;
        dx_d  = dx_q;
        dy_d  = dy_q;
        xo_d  = xo_q;
        yo_d  = yo_q;
        if (frame_err_s) begin
            idx_d = 2'd0;
        end else if (byte_valid_s) begin
            case (idx_q)
                2'd0: begin
                    if (byte_s[SYNC]) begin
                        b0_d  = byte_s;
                        idx_d = 2'd1;
                    end else begin
                        idx_d = 2'd0;
                    end
                end
                2'd1: begin
                    b1_d  = byte_s;
                    idx_d = 2'd2;
                end
                2'd2: begin
                    btn_d = {b0_q[BTN_M], b0_q[BTN_R], b0_q[BTN_L]};
                    dx_d  = {b0_q[XS], b1_q};
                    dy_d  = {b0_q[YS], byte_s};
                    xo_d  = b0_q[XO];
                    yo_d  = b0_q[YO];
                    pv_d  = 1'b1;
                    idx_d = 2'd0;
                end
                default: begin
                    idx_d = 2'd0;
                end
            endcase
        end else begin
            idx_d = idx_q;
        end
    end

    assign byte_data  = byte_s;
    assign byte_valid = byte_valid_s;
    assign frame_err  = frame_err_s;
    assign pkt_valid  = pv_q;
    assign buttons    = btn_q;
    assign dx         = dx_q;
    assign dy         = dy_q;
    assign x_ovf      = xo_q;
    assign y_ovf      = yo_q;

endmodule
